data_memory_unit: RTL and testbench
===================================

# data_memory_unit

Parametrised data memory for the pipelined RISC CPU's MEM stage. It replaces the fixed 64-word, word-only memory with a configurable-depth, byte-addressed store. It supports byte, halfword and word loads and stores, signed and unsigned load extension, and a registered read path. A post-reset initialisation sequencer fills the array one word per cycle and reports readiness through a `ready` output. Misaligned and illegal accesses are flagged with `err` rather than silently corrupting memory.

## Interface

Parameters:
- `DEPTH`, default 64: number of 32-bit words. Must be a power of two, ≥ 4.
- `ADDR_W`, default $clog2(DEPTH)+2: byte-address width. Derived; not overridden.
- `INIT_MODE`, default 1: initial contents. 0 = all words zero; 1 = word k holds k.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `req`, in, 1: access request; sampled only while `ready`=1.
- `we`, in, 1: 1 = store, 0 = load.
- `size`, in, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `uns`, in, 1: load zero-extends when 1, sign-extends when 0. Ignored for stores and word loads.
- `addr`, in, ADDR_W: byte address, little-endian.
- `wdata`, in, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `ready`, out, 1: memory initialised and accepting requests.
- `rvalid`, out, 1: one-cycle response pulse for each accepted request.
- `rdata`, out, 32: load result. 0 for stores and errors.
- `err`, out, 1: qualifies `rvalid`. Set for misaligned access or `size`=11.

## Operation

- **States:** INIT and RUN.
- **Reset asserted (`rst`=0):**
  - State forced to INIT and init counter to 0, asynchronously.
  - `ready`, `rvalid`, `err` = 0; `rdata` = 0.
  - Array contents are not cleared by reset itself.
- **INIT:**
  - Each rising edge writes word k with 0 or k, per `INIT_MODE`, then increments k.
  - After word DEPTH-1 is written, state goes to RUN and `ready`=1.
  - `req` is ignored in INIT; no response is produced.
  - Reset during INIT restarts the sequence from k=0.
- **RUN:** one request accepted per cycle when `req`=1.
  - **Alignment rules:**
    - Half requires `addr[0]`=0.
    - Word requires `addr[1:0]`=0.
    - Byte is always aligned.
    - `size`=11 is always an error.
  - **Error request:** no array write. Next cycle `rvalid`=1, `err`=1, `rdata`=0.
  - **Store:**
    - Word index is `addr[ADDR_W-1:2]`.
    - Only the addressed lanes are written: byte → lane `addr[1:0]`; half → lanes {`addr[1]`*2+1, `addr[1]`*2}.
    - Other bytes of the word are preserved.
    - Next cycle `rvalid`=1, `err`=0, `rdata`=0.
  - **Load:**
    - Word is read and the lane(s) extracted.
    - Result is extended to 32 bits (sign or zero, per `uns`) and registered into `rdata`.
    - `rvalid`=1, `err`=0.
  - **Idle cycle (`req`=0):** `rvalid`=0, `err`=0, `rdata` holds its previous value.
- **Read-after-write:** a load in cycle N+1 to the address stored in cycle N returns the new data. There is no stale-read window.

## Timing

- **Init latency:** `ready` rises after the DEPTH-th rising edge following reset release (64 cycles at default).
- **Load latency:** 1 cycle. A request sampled at edge N produces `rvalid`/`rdata`/`err` valid after edge N, for one cycle.
- **Throughput:** one request per cycle; back-to-back requests give back-to-back `rvalid`.
- **Store visibility:** stores commit at the sampling edge.
- **`ready` deassertion:** `ready` falls only on reset.
- **Reset mid-operation:** a pending response is discarded and all outputs clear immediately, without waiting for a clock edge.

## Test plan

All scenarios use DEPTH=64, INIT_MODE=1.

1. **Init sequence:** release `rst` → `ready`=0 for 64 edges, then 1. Then load word at `addr`=0x14 → `rvalid`=1, `rdata`=0x00000005, `err`=0.
2. **Byte store and loads:** store byte 0x80 at 0x21. Then:
   - load byte signed at 0x21 → 0xFFFFFF80;
   - load byte unsigned at 0x21 → 0x00000080;
   - load word at 0x20 → 0x00008008.
3. **Halfword store and loads:** store half 0xBEEF at 0x06. Then:
   - load word at 0x04 → 0xBEEF0001;
   - load half signed at 0x06 → 0xFFFFBEEF;
   - load half unsigned at 0x06 → 0x0000BEEF.
4. **Error cases:**
   - load word at 0x02 → `err`=1, `rdata`=0;
   - store half at 0x03 → `err`=1; a following load word at 0x00 → 0x00000000 (memory unchanged);
   - `size`=11 → `err`=1.
5. **Back-to-back read-after-write:** store word 0xDEADBEEF at 0x40, then load word at 0x40 in the next cycle → `rvalid` high on both cycles, second `rdata`=0xDEADBEEF.
6. **Reset mid-operation and mid-init:**
   - Assert `rst` between clock edges while `rvalid`=1 → `rvalid`/`ready` drop without waiting for a clock edge.
   - After release, re-assert at init cycle 30, then release → init restarts from k=0, `ready` rises 64 edges after the final release, and word 16 reads 0x00000010.

Source files
------------

// File: rtl/data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_unit
// Brief    : Byte-addressed MEM-stage data memory with sub-word access,
//            post-reset init sequencer and a registered read path.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_unit #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = $clog2(DEPTH) + 2,
  parameter int INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int                 c_IDX_W = ADDR_W - 2;
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_IDX_W-1:0] r_cnt;
  logic               r_ready;
  logic               r_rvalid;
  logic               r_err;
  logic [31:0]        r_rdata;
  logic [31:0]        r_mem [DEPTH];

  logic [c_IDX_W-1:0] w_idx;
  logic [1:0]         w_lane;
  logic               w_bad;
  logic               w_acc;
  logic               w_st;
  logic [3:0]         w_be;
  logic [31:0]        w_wword;
  logic [31:0]        w_rword;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_ld;

  assign w_idx   = addr[ADDR_W-1:2];
  assign w_lane  = addr[1:0];
  assign w_acc   = (r_state == S_RUN) && req;
  assign w_st    = w_acc && we && !w_bad;
  assign w_rword = r_mem[w_idx];
  assign w_byte  = w_rword[{w_lane, 3'b000} +: 8];
  assign w_half  = w_rword[{addr[1], 4'b0000} +: 16];

  always_comb begin
    w_bad   = 1'b0;
    w_be    = 4'b0000;
    w_wword = wdata;
    w_ld    = w_rword;
    case (size)
      2'b00: begin
        w_be[w_lane] = 1'b1;
        w_wword      = {4{wdata[7:0]}};
        w_ld         = {{24{~uns & w_byte[7]}}, w_byte};
      end
      2'b01: begin
        w_bad   = addr[0];
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wword = {2{wdata[15:0]}};
        w_ld    = {{16{~uns & w_half[15]}}, w_half};
      end
      2'b10: begin
        w_bad = (w_lane != 2'b00);
        w_be  = 4'b1111;
      end
      default: w_bad = 1'b1;
    endcase
  end

  // Array has no reset: the init sequencer rewrites every word after reset.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_cnt] <= (INIT_MODE == 1) ? 32'(r_cnt) : 32'd0;
    end else if (w_st) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_INIT;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_rvalid <= w_acc;
      r_err    <= w_acc && w_bad;
      case (r_state)
        S_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_acc) r_rdata <= (we || w_bad) ? 32'd0 : w_ld;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign ready  = r_ready;
  assign rvalid = r_rvalid;
  assign err    = r_err;
  assign rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_unit
// Brief    : Directed plus random checks of data_memory_unit against a
//            byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'd0;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int          vectors = 0;
  int          miscompares = 0;
  byte unsigned mem_b [256];
  logic [31:0] last_rdata = 32'd0;

  always #5 clk = ~clk;

  data_memory_unit #(.DEPTH(64), .INIT_MODE(1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .rvalid(rvalid),
    .rdata(rdata), .err(err)
  );

  // Memory viewed as little-endian bytes; word k initially holds k.
  function automatic void model_init();
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 4; j++)
        mem_b[4*k+j] = (j == 0) ? 8'(k) : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit w, input bit [1:0] s, input bit u,
                        input bit [7:0] a, input bit [31:0] d);
    int          n;
    bit          bad;
    logic [31:0] v;
    n   = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    bad = (s == 2'd3) || ((a % n) != 0);
    v   = 32'd0;
    if (!bad && w) begin
      for (int j = 0; j < n; j++) mem_b[a+j] = 8'(d >> (8*j));
    end else if (!bad) begin
      for (int j = 0; j < n; j++) v |= 32'(mem_b[a+j]) << (8*j);
      if (!u && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8*n)) - 32'd1);
    end
    req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    chk("rvalid", {31'd0, rvalid}, 32'd1);
    chk("err", {31'd0, err}, {31'd0, bad});
    chk("rdata", rdata, v);
    last_rdata = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_rvalid", {31'd0, rvalid}, 32'd0);
      chk("idle_err", {31'd0, err}, 32'd0);
      chk("idle_rdata_hold", rdata, last_rdata);
    end
  endtask

  initial begin
    bit [1:0] rs;
    bit [7:0] ra;
    model_init();
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);

    // Requests during init must be ignored.
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b1; we = 1'b0; size = 2'b10; addr = 8'h14;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      chk("init_ready", {31'd0, ready}, (i == 64) ? 32'd1 : 32'd0);
      chk("init_rvalid", {31'd0, rvalid}, 32'd0);
    end
    req = 1'b0;

    access(1'b0, 2'd2, 1'b0, 8'h14, 32'd0);
    chk("t1_word5", rdata, 32'h0000_0005);

    access(1'b1, 2'd0, 1'b0, 8'h21, 32'h0000_0080);
    access(1'b0, 2'd0, 1'b0, 8'h21, 32'd0);
    chk("t2_lb", rdata, 32'hFFFF_FF80);
    access(1'b0, 2'd0, 1'b1, 8'h21, 32'd0);
    chk("t2_lbu", rdata, 32'h0000_0080);
    access(1'b0, 2'd2, 1'b0, 8'h20, 32'd0);
    chk("t2_lw", rdata, 32'h0000_8008);

    access(1'b1, 2'd1, 1'b0, 8'h06, 32'h0000_BEEF);
    access(1'b0, 2'd2, 1'b0, 8'h04, 32'd0);
    chk("t3_lw", rdata, 32'hBEEF_0001);
    access(1'b0, 2'd1, 1'b0, 8'h06, 32'd0);
    chk("t3_lh", rdata, 32'hFFFF_BEEF);
    access(1'b0, 2'd1, 1'b1, 8'h06, 32'd0);
    chk("t3_lhu", rdata, 32'h0000_BEEF);

    access(1'b0, 2'd2, 1'b0, 8'h02, 32'd0);
    chk("t4_lw_misalign_err", {31'd0, err}, 32'd1);
    access(1'b1, 2'd1, 1'b0, 8'h03, 32'h0000_FFFF);
    chk("t4_sh_misalign_err", {31'd0, err}, 32'd1);
    access(1'b0, 2'd2, 1'b0, 8'h00, 32'd0);
    chk("t4_word0_unchanged", rdata, 32'd0);
    access(1'b0, 2'd3, 1'b0, 8'h10, 32'd0);
    chk("t4_size11_err", {31'd0, err}, 32'd1);
    idle(2);

    access(1'b1, 2'd2, 1'b0, 8'h40, 32'hDEAD_BEEF);
    access(1'b0, 2'd2, 1'b0, 8'h40, 32'd0);
    chk("t5_raw", rdata, 32'hDEAD_BEEF);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        rs = 2'($urandom_range(0, 3));
        ra = 8'($urandom);
        if ($urandom_range(0, 1) == 1)
          ra = (rs == 2'd1) ? {ra[7:1], 1'b0} : (rs == 2'd2) ? {ra[7:2], 2'b00} : ra;
        access(1'($urandom), rs, 1'($urandom), ra, $urandom);
      end
    end

    // Asynchronous reset while a response is being presented.
    access(1'b0, 2'd2, 1'b0, 8'h40, 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_async_rvalid", {31'd0, rvalid}, 32'd0);
    chk("t6_async_ready", {31'd0, ready}, 32'd0);
    chk("t6_async_err", {31'd0, err}, 32'd0);
    chk("t6_async_rdata", rdata, 32'd0);
    #3;
    rst = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      chk("t6_midinit_ready", {31'd0, ready}, 32'd0);
    end
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_init();
    last_rdata = 32'd0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      chk("t6_reinit_ready", {31'd0, ready}, (i == 64) ? 32'd1 : 32'd0);
    end
    access(1'b0, 2'd2, 1'b0, 8'h40, 32'd0);
    chk("t6_word16", rdata, 32'h0000_0010);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
